// File: rtl/d5m_emu_pkg.sv
// Shared types and constants for the D5M sensor emulator.
package d5m_emu_pkg;

    localparam int DATA_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_PRE  = 3'd1,
        ST_LINE   = 3'd2,
        ST_H_GAP  = 3'd3,
        ST_F_POST = 3'd4,
        ST_V_GAP  = 3'd5
    } emu_state_t;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CONST   = 2'd2,
        PAT_BAYER   = 2'd3
    } pattern_t;

    localparam logic [DATA_W-1:0] BAYER_G = 12'h800;
    localparam logic [DATA_W-1:0] BAYER_R = 12'hFFF;
    localparam logic [DATA_W-1:0] BAYER_B = 12'h000;

    // Pixel value for one active pixel. Only the low 12 bits of row, col and
    // width matter: the counter pattern is taken modulo 4096 anyway.
    function automatic logic [DATA_W-1:0] pattern_pixel(
        input pattern_t          sel,
        input logic [DATA_W-1:0] row_lo,
        input logic [DATA_W-1:0] col_lo,
        input logic [DATA_W-1:0] const_value,
        input logic [DATA_W-1:0] width_lo
    );
        logic [DATA_W-1:0] px;
        case (sel)
            PAT_COUNTER: px = row_lo * width_lo + col_lo;
            PAT_RAMP:    px = col_lo;
            PAT_CONST:   px = const_value;
            PAT_BAYER: begin
                case ({row_lo[0], col_lo[0]})
                    2'b00:   px = BAYER_G;
                    2'b01:   px = BAYER_R;
                    2'b10:   px = BAYER_B;
                    2'b11:   px = BAYER_G;
                    default: px = BAYER_G;
                endcase
            end
            default:     px = {DATA_W{1'b0}};
        endcase
        return px;
    endfunction

endpackage

// File: rtl/d5m_sensor_emulator_pixclk_gen.sv
// Pixel clock divider: free-running div_cnt, registered pixclk and the
// pix_tick strobe marking the clk edge on which pixclk rises.
module d5m_pixclk_gen #(
    parameter int PIXCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic cam_pixclk,
    output logic pix_tick
);

    localparam int CNT_W = $clog2(PIXCLK_DIV);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_next;

    assign pix_tick = (div_cnt == CNT_W'(PIXCLK_DIV - 1));

    // Next divider value, wrapping at PIXCLK_DIV-1.
    always_comb begin
        if (pix_tick) begin
            div_next = {CNT_W{1'b0}};
        end else begin
            div_next = div_cnt + CNT_W'(1);
        end
    end

    // Divider register; pixclk is derived from the next count so it rises on
    // the same edge that the frame outputs update.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= {CNT_W{1'b0}};
            cam_pixclk <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            cam_pixclk <= (div_next < CNT_W'(PIXCLK_DIV / 2));
        end
    end

endmodule

// File: rtl/d5m_sensor_emulator.sv
// D5M sensor emulator: generates FVAL/LVAL/DATA frames on an emulated pixel
// clock, continuously or one frame per trigger.
module d5m_sensor_emulator
    import d5m_emu_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int H_BLANK      = 32,
    parameter int F2L_BLANK    = 4,
    parameter int V_BLANK      = 64,
    parameter int PIXCLK_DIV   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              snapshot_mode,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] const_value,
    input  logic              cam_reset_n,
    input  logic              cam_trigger,
    output logic              cam_pixclk,
    output logic              cam_fval,
    output logic              cam_lval,
    output logic [DATA_W-1:0] cam_data,
    output logic [15:0]       frame_count,
    output logic              busy
);

    logic              pix_tick;
    emu_state_t        state, state_n;
    logic [15:0]       cnt, cnt_n;
    logic [15:0]       row, row_n;
    logic [15:0]       dur;
    logic              last, go, start, frame_done;
    logic              fval_n, lval_n;
    logic [DATA_W-1:0] data_n;
    pattern_t          pat_lat;
    logic [DATA_W-1:0] const_lat;
    logic              snap_lat;
    logic              pending, trig_d, snap_eff;

    d5m_pixclk_gen #(.PIXCLK_DIV(PIXCLK_DIV)) u_pixclk (
        .clk        (clk),
        .reset      (reset),
        .cam_pixclk (cam_pixclk),
        .pix_tick   (pix_tick)
    );

    assign go       = enable & (~snapshot_mode | pending);
    assign last     = (cnt == dur - 16'd1);
    // While a frame runs, the mode it was started with decides whether
    // triggers are stored.
    assign snap_eff = (state == ST_IDLE) ? snapshot_mode : snap_lat;

    // Tick length of the current state.
    always_comb begin
        case (state)
            ST_F_PRE:  dur = 16'(F2L_BLANK);
            ST_LINE:   dur = 16'(FRAME_WIDTH);
            ST_H_GAP:  dur = 16'(H_BLANK);
            ST_F_POST: dur = 16'(F2L_BLANK);
            ST_V_GAP:  dur = 16'(V_BLANK);
            default:   dur = 16'd1;
        endcase
    end

    // Next state, tick/row counters and frame start/end strobes, applied on pix_tick.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 16'd1;
        row_n      = row;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = 16'd0;
                if (go) begin
                    state_n = ST_F_PRE;
                    row_n   = 16'd0;
                    start   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_F_PRE: begin
                if (last) begin
                    state_n = ST_LINE;
                    cnt_n   = 16'd0;
                end else begin
                    state_n = ST_F_PRE;
                end
            end
            ST_LINE: begin
                if (last) begin
                    cnt_n   = 16'd0;
                    row_n   = row + 16'd1;
                    state_n = (row + 16'd1 < 16'(FRAME_HEIGHT)) ? ST_H_GAP : ST_F_POST;
                end else begin
                    state_n = ST_LINE;
                end
            end
            ST_H_GAP: begin
                if (last) begin
                    state_n = ST_LINE;
                    cnt_n   = 16'd0;
                end else begin
                    state_n = ST_H_GAP;
                end
            end
            ST_F_POST: begin
                if (last) begin
                    state_n    = ST_V_GAP;
                    cnt_n      = 16'd0;
                    frame_done = 1'b1;
                end else begin
                    state_n = ST_F_POST;
                end
            end
            ST_V_GAP: begin
                if (last) begin
                    cnt_n = 16'd0;
                    if (go) begin
                        state_n = ST_F_PRE;
                        row_n   = 16'd0;
                        start   = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_V_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 16'd0;
                row_n   = 16'd0;
            end
        endcase
    end

    // Conduit outputs corresponding to the next state.
    always_comb begin
        fval_n = (state_n == ST_F_PRE) || (state_n == ST_LINE) ||
                 (state_n == ST_H_GAP) || (state_n == ST_F_POST);
        lval_n = (state_n == ST_LINE);
        if (lval_n) begin
            data_n = pattern_pixel(pat_lat, row_n[DATA_W-1:0], cnt_n[DATA_W-1:0],
                                   const_lat, DATA_W'(FRAME_WIDTH));
        end else begin
            data_n = {DATA_W{1'b0}};
        end
    end

    // Frame FSM, counters and registered outputs; cam_reset_n aborts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 16'd0;
            row         <= 16'd0;
            cam_fval    <= 1'b0;
            cam_lval    <= 1'b0;
            cam_data    <= {DATA_W{1'b0}};
            busy        <= 1'b0;
            frame_count <= 16'd0;
            pat_lat     <= PAT_COUNTER;
            const_lat   <= {DATA_W{1'b0}};
            snap_lat    <= 1'b0;
        end else if (!cam_reset_n) begin
            state    <= ST_IDLE;
            cnt      <= 16'd0;
            row      <= 16'd0;
            cam_fval <= 1'b0;
            cam_lval <= 1'b0;
            cam_data <= {DATA_W{1'b0}};
            busy     <= 1'b0;
        end else if (pix_tick) begin
            state       <= state_n;
            cnt         <= cnt_n;
            row         <= row_n;
            cam_fval    <= fval_n;
            cam_lval    <= lval_n;
            cam_data    <= data_n;
            busy        <= (state_n != ST_IDLE);
            frame_count <= frame_count + {15'd0, frame_done};
            if (start) begin
                pat_lat   <= pattern_t'(pattern_sel);
                const_lat <= const_value;
                snap_lat  <= snapshot_mode;
            end
        end
    end

    // Snapshot trigger: a rising edge stores one pending request until a frame starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_d  <= 1'b0;
            pending <= 1'b0;
        end else begin
            trig_d <= cam_trigger;
            if (!cam_reset_n) begin
                pending <= 1'b0;
            end else if (cam_trigger && !trig_d && snap_eff) begin
                pending <= 1'b1;
            end else if (pix_tick && start) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
